// File: rtl/instr_trace.sv
// Retired-instruction trace buffer with PC/exception trigger, post-trigger capture window
// and oldest-first readout; each entry carries a right-aligned ASCII MIPS mnemonic.
//   state  | meaning
//   IDLE   | buffer inactive, waiting for arm
//   ARMED  | capturing, watching for trigger
//   POST   | capturing the post-trigger window
//   FROZEN | capture stopped, draining via readout handshake
module instr_trace #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int MN_W      = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     arm_i,
  input  logic [1:0]               trig_mode_i,
  input  logic [31:0]              trig_pc_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_instr_o,
  output logic [MN_W-1:0]          rd_mn_o,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, FROZEN = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr;
  logic [CW-1:0]   count, count_nxt, post_cnt, post_cnt_nxt;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [MN_W-1:0] mn_mem    [DEPTH];
  logic [47:0]     dec_mn;
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt;
  logic            exc, trig, capture, accept, rd_valid;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];
  assign funct = instr_i[5:0];

  always_comb begin
    dec_mn = 48'("N-R");
    if (instr_i == 32'h0) begin
      dec_mn = 48'("NOP");
    end else if (instr_i == 32'h4200_0018) begin
      dec_mn = 48'("ERET");
    end else begin
      case (op)
        6'h00: begin
          case (funct)
            6'h00: dec_mn = 48'("SLL");    6'h02: dec_mn = 48'("SRL");
            6'h03: dec_mn = 48'("SRA");    6'h04: dec_mn = 48'("SLLV");
            6'h06: dec_mn = 48'("SRLV");   6'h07: dec_mn = 48'("SRAV");
            6'h08: dec_mn = 48'("JR");     6'h09: dec_mn = 48'("JALR");
            6'h0C: dec_mn = 48'("SYSC");   6'h0D: dec_mn = 48'("BRE");
            6'h10: dec_mn = 48'("MFHI");   6'h11: dec_mn = 48'("MTHI");
            6'h12: dec_mn = 48'("MFLO");   6'h13: dec_mn = 48'("MTLO");
            6'h18: dec_mn = 48'("MULT");   6'h19: dec_mn = 48'("MULTU");
            6'h1A: dec_mn = 48'("DIV");    6'h1B: dec_mn = 48'("DIVU");
            6'h20: dec_mn = 48'("ADD");    6'h21: dec_mn = 48'("ADDU");
            6'h22: dec_mn = 48'("SUB");    6'h23: dec_mn = 48'("SUBU");
            6'h24: dec_mn = 48'("AND");    6'h25: dec_mn = 48'("OR");
            6'h26: dec_mn = 48'("XOR");    6'h27: dec_mn = 48'("NOR");
            6'h2A: dec_mn = 48'("SLT");    6'h2B: dec_mn = 48'("SLTU");
            default: dec_mn = 48'("N-R");
          endcase
        end
        6'h01: begin
          case (rt)
            5'h00: dec_mn = 48'("BLTZ");   5'h01: dec_mn = 48'("BGEZ");
            5'h10: dec_mn = 48'("BLTZAL"); 5'h11: dec_mn = 48'("BGEZAL");
            default: dec_mn = 48'("N-R");
          endcase
        end
        6'h02: dec_mn = 48'("J");      6'h03: dec_mn = 48'("JAL");
        6'h04: dec_mn = 48'("BEQ");    6'h05: dec_mn = 48'("BNE");
        6'h06: dec_mn = 48'("BLEZ");   6'h07: dec_mn = 48'("BGTZ");
        6'h08: dec_mn = 48'("ADDI");   6'h09: dec_mn = 48'("ADDIU");
        6'h0A: dec_mn = 48'("SLTI");   6'h0B: dec_mn = 48'("SLTIU");
        6'h0C: dec_mn = 48'("ANDI");   6'h0D: dec_mn = 48'("ORI");
        6'h0E: dec_mn = 48'("XORI");   6'h0F: dec_mn = 48'("LUI");
        6'h10: begin
          case (rs)
            5'h00: dec_mn = 48'("MFC0");   5'h04: dec_mn = 48'("MTC0");
            default: dec_mn = 48'("N-R");
          endcase
        end
        6'h20: dec_mn = 48'("LB");     6'h21: dec_mn = 48'("LH");
        6'h22: dec_mn = 48'("LWL");    6'h23: dec_mn = 48'("LW");
        6'h24: dec_mn = 48'("LBU");    6'h25: dec_mn = 48'("LHU");
        6'h26: dec_mn = 48'("LWR");    6'h28: dec_mn = 48'("SB");
        6'h29: dec_mn = 48'("SH");     6'h2A: dec_mn = 48'("SWL");
        6'h2B: dec_mn = 48'("SW");     6'h2E: dec_mn = 48'("SWR");
        default: dec_mn = 48'("N-R");
      endcase
    end
  end

  assign exc      = (op == 6'h00 && (funct == 6'h0C || funct == 6'h0D)) || (instr_i == 32'h4200_0018);
  assign trig     = (trig_mode_i[0] && pc_i == trig_pc_i) || (trig_mode_i[1] && exc);
  // An arm pulse always wins over a same-cycle capture.
  assign capture  = valid_i && !arm_i && (state == ARMED || state == POST);
  assign rd_valid = (state == FROZEN) && (count != '0);
  assign accept   = rd_valid && rd_ready_i;
  assign rd_ptr   = wr_ptr - count[AW-1:0];

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    count_nxt    = count;
    post_cnt_nxt = post_cnt;
    if (arm_i) begin
      state_nxt    = ARMED;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
      post_cnt_nxt = '0;
    end else begin
      if (capture) begin
        wr_ptr_nxt = wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) count_nxt = count + CW'(1);
      end
      case (state)
        ARMED: begin
          if (valid_i && trig) begin
            if (POST_TRIG == 0) begin
              state_nxt = FROZEN;
            end else begin
              state_nxt    = POST;
              post_cnt_nxt = CW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (valid_i) begin
            post_cnt_nxt = post_cnt - CW'(1);
            if (post_cnt == CW'(1)) state_nxt = FROZEN;
          end
        end
        FROZEN: begin
          if (accept) begin
            count_nxt = count - CW'(1);
            if (count == CW'(1)) state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      post_cnt <= post_cnt_nxt;
    end
  end

  // Storage is never cleared; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
      mn_mem[wr_ptr]    <= MN_W'(dec_mn);
    end
  end

  assign rd_valid_o = rd_valid;
  assign rd_pc_o    = rd_valid ? pc_mem[rd_ptr]    : '0;
  assign rd_instr_o = rd_valid ? instr_mem[rd_ptr] : '0;
  assign rd_mn_o    = rd_valid ? mn_mem[rd_ptr]    : '0;
  assign state_o    = state;
  assign count_o    = count;

endmodule

// File: doc/instr_trace.md
INSTR_TRACE -- requirements
Module: instr_trace

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the trace buffer entry count; power of 2, range 2..256.
REQ-002 Parameter POST_TRIG, default 4, SHALL set the number of valid instructions captured after the trigger entry; range 0..DEPTH-1.
REQ-003 Parameter MN_W, default 48, SHALL set the mnemonic field width in bits (8 bits per ASCII character); minimum 48, so that "BGEZAL" fits.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 valid_i  in  1  a retired instruction is present this cycle.
REQ-007 pc_i  in  32  PC of the retired instruction.
REQ-008 instr_i  in  32  retired instruction word.
REQ-009 arm_i  in  1  single-cycle pulse that clears the buffer and starts capture.
REQ-010 trig_mode_i  in  2  trigger mode: 00 none, 01 PC match, 10 exception-class instruction, 11 either.
REQ-011 trig_pc_i  in  32  PC compare value.
REQ-012 rd_valid_o  out  1  a readout entry is available.
REQ-013 rd_ready_i  in  1  the consumer accepts the entry.
REQ-014 rd_pc_o  out  32  PC field of the readout entry.
REQ-015 rd_instr_o  out  32  instruction field of the readout entry.
REQ-016 rd_mn_o  out  MN_W  ASCII mnemonic of the readout entry.
REQ-017 state_o  out  2  current state: 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN.
REQ-018 count_o  out  clog2(DEPTH)+1  number of valid entries in the buffer.

Function
REQ-019 The mnemonic decoder SHALL cover the MIPS-I subset plus ERET, MTC0 and MFC0: R-type logic/shift/move/arith/mult/div/JR/JALR/SYSCALL("SYSC")/BREAK("BRE"), I-type, J-type, branches, loads/stores, and REGIMM BGEZ/BGEZAL/BLTZ/BLTZAL.
REQ-020 Decode priority SHALL be: instr==0 gives "NOP"; instr==32'h42000018 gives "ERET"; otherwise the table lookup; any unmatched opcode, funct, REGIMM rt or COP0 rs gives "N-R".
REQ-021 Mnemonics SHALL be right-aligned, with unused upper bytes zero.
REQ-022 Exception-class instructions are defined as SYSCALL, BREAK and ERET.
REQ-023 A capture happens when valid_i=1 in ARMED or POST; the entry {pc_i, instr_i, decoded mnemonic} SHALL be written at wr_ptr on that edge.
REQ-024 On each capture, wr_ptr SHALL increment modulo DEPTH.
REQ-025 On each capture, count SHALL increment and saturate at DEPTH; when full, the oldest entry is overwritten.
REQ-026 State IDLE: arm_i SHALL clear count and wr_ptr and move to ARMED next cycle.
REQ-027 State ARMED: a capture whose trigger condition holds SHALL move to POST with post_cnt=POST_TRIG, or directly to FROZEN if POST_TRIG=0.
REQ-028 Trigger condition: (mode bit0 and pc_i==trig_pc_i) or (mode bit1 and the instruction is exception-class). Mode 00 never triggers.
REQ-029 State POST: each capture SHALL decrement post_cnt; the capture that takes post_cnt from 1 to 0 SHALL move to FROZEN. Triggers in POST are ignored.
REQ-030 State FROZEN: no captures. rd_ptr SHALL equal (wr_ptr - count) mod DEPTH, i.e. readout is oldest first.
REQ-031 rd_valid_o SHALL equal (state==FROZEN and count!=0).
REQ-032 rd_* outputs SHALL combinationally reflect the entry at rd_ptr and SHALL be 0 whenever rd_valid_o=0.
REQ-033 Readout handshake: on rd_valid_o and rd_ready_i, count SHALL decrement; the next entry is presented the following cycle (one entry per cycle maximum).
REQ-034 When the last entry is accepted (count 1 to 0), the state SHALL return to IDLE next cycle.
REQ-035 arm_i in ARMED, POST or FROZEN SHALL abort: count and wr_ptr clear, state becomes ARMED, and any capture in that same cycle is discarded.
REQ-036 If arm_i and valid_i coincide in IDLE, the instruction SHALL NOT be captured.
REQ-037 Entry storage contents are not required to be cleared; visibility is governed solely by count.

Reset
REQ-038 On rst=1 at a clock edge: state IDLE, wr_ptr 0, count 0, post_cnt 0, rd_valid_o 0 and all rd_* outputs 0; rst overrides arm_i and valid_i.
REQ-039 A reset during POST or FROZEN SHALL discard all captured entries, with no readout afterwards.

Verification
REQ-040 Decode sweep: drive each supported encoding plus 0, 32'h42000018, opcode 6'h3F and REGIMM rt=5'b00010 through a DEPTH=16, trig_mode 10 trace; check rd_mn_o gives every mnemonic, "NOP", "ERET", "N-R", "N-R", with "BGEZAL" full width.
REQ-041 Wrap: DEPTH=4, POST_TRIG=2, arm, then 10 instructions with PCs 0x00..0x24 and a SYSCALL at PC 0x1C; check FROZEN after PC 0x24, count=4, readout PCs 0x18, 0x1C, 0x20, 0x24.
REQ-042 PC trigger with POST_TRIG=0: trig_pc 0x40, instruction at 0x40; check FROZEN the next cycle with the last entry PC 0x40; valid_i held high afterwards adds no entries.
REQ-043 Backpressure: in FROZEN with count=3, toggle rd_ready_i 1,0,1,0,1; check exactly 3 accepts, data stable while stalled, rd_valid_o=0 and state IDLE after the last accept.
REQ-044 Abort and reset: arm_i in POST with valid_i=1 gives ARMED, count=0; rst asserted in FROZEN gives IDLE, rd_valid_o=0, all rd_* outputs 0 on the next cycle.
